// File: rtl/button_flag_array.sv
// button_flag_array: per-channel synchronized, debounced buttons with press/release,
// long-press and auto-repeat one-cycle flags.
module button_flag_array #(
    parameter int N_BTN  = 4,
    parameter int DB_W   = 6,
    parameter int LONG_W = 12,
    parameter int RPT_W  = 10
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic [N_BTN-1:0] bt,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_flag,
    output logic [N_BTN-1:0] release_flag,
    output logic [N_BTN-1:0] long_flag,
    output logic [N_BTN-1:0] rpt_flag,
    output logic             any_press
);
    localparam logic [LONG_W-1:0] LONG_PRE = {LONG_W{1'b1}} - LONG_W'(1);

    assign any_press = |press_flag;

    genvar i;
    for (i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]        sync;
        logic [DB_W-1:0]   db_cnt;
        logic [LONG_W-1:0] hold;
        logic [RPT_W-1:0]  rpt;
        logic              lvl, prs, rel, lng, rep;
        logic              bt_s, diff, flip, fall, held, hold_sat, rpt_run;
        assign bt_s     = sync[1];
        assign diff     = bt_s ^ lvl;
        assign flip     = diff && (db_cnt == '1);
        assign fall     = flip && lvl;
        // held excludes the releasing edge so hold and rpt clear together with the flag
        assign held     = lvl && !fall;
        assign hold_sat = hold == '1;
        assign rpt_run  = held && hold_sat && rpt_en[i];
        always_ff @(posedge clk_d or posedge rst) begin
            if (rst) begin
                sync   <= '0;
                db_cnt <= '0;
                hold   <= '0;
                rpt    <= '0;
                lvl    <= 1'b0;
                prs    <= 1'b0;
                rel    <= 1'b0;
                lng    <= 1'b0;
                rep    <= 1'b0;
            end else begin
                sync   <= {sync[0], bt[i]};
                db_cnt <= (diff && !flip) ? db_cnt + DB_W'(1) : '0;
                lvl    <= lvl ^ flip;
                prs    <= flip && !lvl;
                rel    <= fall;
                hold   <= held ? (hold_sat ? hold : hold + LONG_W'(1)) : '0;
                lng    <= held && (hold == LONG_PRE);
                rpt    <= rpt_run ? rpt + RPT_W'(1) : '0;
                rep    <= rpt_run && (rpt == '1);
            end
        end
        assign level[i]        = lvl;
        assign press_flag[i]   = prs;
        assign release_flag[i] = rel;
        assign long_flag[i]    = lng;
        assign rpt_flag[i]     = rep;
    end
endmodule

// File: tb/tb_button_flag_array.sv
// tb_button_flag_array: directed scenarios with hand-computed edge numbers
// (DB_W=3, LONG_W=5, RPT_W=3, N_BTN=4).
module tb_button_flag_array;
    logic       clk_d = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] bt     = '0;
    logic [3:0] rpt_en = 4'b0100;
    logic [3:0] level, press_flag, release_flag, long_flag, rpt_flag;
    logic       any_press;
    int checks = 0;
    int errors = 0;

    button_flag_array #(.N_BTN(4), .DB_W(3), .LONG_W(5), .RPT_W(3)) dut (
        .clk_d(clk_d), .rst(rst), .bt(bt), .rpt_en(rpt_en), .level(level),
        .press_flag(press_flag), .release_flag(release_flag), .long_flag(long_flag),
        .rpt_flag(rpt_flag), .any_press(any_press)
    );

    always #5 clk_d = ~clk_d;

    task automatic step();
        @(posedge clk_d);
        @(negedge clk_d);
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        checks++;
        if ({level, press_flag, release_flag, long_flag, rpt_flag, any_press} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {level, press_flag, release_flag, long_flag, rpt_flag, any_press});
        end
        @(negedge clk_d);
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        bt[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            checks++;
            if (press_flag[0] !== (k == 10) || level[0] !== (k >= 10) || any_press !== (k == 10)) begin
                errors++;
                $display("FAIL clean_press edge %0d got p=%b l=%b a=%b", k, press_flag[0], level[0], any_press);
            end
        end
        bt[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (release_flag[0] !== (k == 10) || level[0] !== (k < 10)) begin
                errors++;
                $display("FAIL clean_release edge %0d got r=%b l=%b", k, release_flag[0], level[0]);
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            bt[1] = (k != 7);
            step();
            pulses += int'(press_flag[1]);
            checks++;
            if (press_flag[1] !== (k == 17)) begin
                errors++;
                $display("FAIL bounce_press edge %0d got %b want %b", k, press_flag[1], k == 17);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_count got %0d want 1", pulses);
        end
        bt[1] = 1'b0;
        settle(12);
    endtask

    task automatic test_long_repeat();
        bt[2] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 71) bt[2] = 1'b0;
            step();
            checks++;
            if (long_flag[2] !== (k == 41) || release_flag[2] !== (k == 80) ||
                rpt_flag[2] !== (k >= 49 && k <= 73 && (k - 49) % 8 == 0)) begin
                errors++;
                $display("FAIL long_repeat edge %0d got l=%b r=%b rel=%b", k, long_flag[2], rpt_flag[2], release_flag[2]);
            end
        end
    endtask

    task automatic test_rpt_en_toggle();
        bt[2] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            if (k == 45) rpt_en[2] = 1'b0;
            if (k == 51) rpt_en[2] = 1'b1;
            step();
            checks++;
            if (long_flag[2] !== (k == 41) || rpt_flag[2] !== (k == 58 || k == 66)) begin
                errors++;
                $display("FAIL rpt_en_toggle edge %0d got l=%b r=%b", k, long_flag[2], rpt_flag[2]);
            end
        end
        bt[2] = 1'b0;
        settle(12);
    endtask

    task automatic test_no_repeat();
        int longs = 0;
        int rpts  = 0;
        bt[3] = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            step();
            longs += int'(long_flag[3]);
            rpts  += int'(rpt_flag[3]);
        end
        checks++;
        if (longs != 1 || rpts != 0) begin
            errors++;
            $display("FAIL no_repeat got long=%0d rpt=%0d want 1 0", longs, rpts);
        end
        bt[3] = 1'b0;
        settle(12);
    endtask

    task automatic test_simultaneous();
        bt = 4'b1001;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (press_flag !== (k == 10 ? 4'b1001 : 4'b0000) || any_press !== (k == 10)) begin
                errors++;
                $display("FAIL simultaneous edge %0d got p=%b a=%b", k, press_flag, any_press);
            end
        end
        bt = 4'b0000;
        settle(12);
    endtask

    task automatic test_reset_mid_hold();
        bt[0] = 1'b1;
        settle(30);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({level, press_flag, release_flag, long_flag, rpt_flag, any_press} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold got %h want 0",
                     {level, press_flag, release_flag, long_flag, rpt_flag, any_press});
        end
        settle(2);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (press_flag[0] !== (k == 10) || level[0] !== (k >= 10) || release_flag[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_repress edge %0d got p=%b l=%b r=%b", k, press_flag[0], level[0], release_flag[0]);
            end
        end
        bt[0] = 1'b0;
        settle(12);
    endtask

    initial begin
        settle(3);
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_rpt_en_toggle();
        test_no_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
